// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer FSM state encoding and default widths,
// used by apb_master and apb_slave.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_WIDTH     = 8;
    localparam int DEFAULT_DATA_WIDTH     = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait counter: cleared before ACCESS, counts cycles without pready,
// flags expiry once LIMIT-1 wait cycles have been counted.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count_reg;

    // Expiry is decoded from the counter register only, so pready never
    // reaches an output combinationally through this block.
    assign expired = (count_reg == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (tick && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-command APB master: IDLE -> SETUP -> ACCESS -> RESP.
// Optional ACCESS timeout enabled with macro APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
`ifdef APB_MASTER_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
`endif
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pstrb,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   paddr_reg;
    logic [DATA_WIDTH-1:0]   pwdata_reg;
    logic                    pwrite_reg;
    logic                    pstrb_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic                    rsp_err_reg;
    logic                    timer_expired;

    // Handshake and APB phase signals are pure decodes of the state register,
    // which lets an asynchronous reset drop psel/penable immediately.
    assign cmd_ready = (state_reg == IDLE);
    assign psel      = (state_reg == SETUP) || (state_reg == ACCESS);
    assign penable   = (state_reg == ACCESS);
    assign rsp_valid = (state_reg == RESP);

    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign pwrite    = pwrite_reg;
    assign pstrb     = pstrb_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

`ifdef APB_MASTER_TIMEOUT_EN
    apb_wait_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_reg == SETUP),
        .tick    ((state_reg == ACCESS) && !pready),
        .expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pwrite_reg    <= 1'b0;
            pstrb_reg     <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The APB address/data registers double as the command capture.
                    if (cmd_valid) begin
                        paddr_reg  <= cmd_addr;
                        pwdata_reg <= cmd_wdata;
                        pwrite_reg <= cmd_write;
                        pstrb_reg  <= cmd_strb;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    state_reg <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata_reg <= pwrite_reg ? '0 : prdata;
                        rsp_err_reg   <= pslverr;
                        state_reg     <= RESP;
                    end else if (timer_expired) begin
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= 1'b1;
                        state_reg     <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Directed table-driven bench for apb_master with a small memory-backed
// APB completer; covers latency, wait states, errors, timeout and reset.
module tb_apb_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       cmd_strb;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       pstrb;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int total_checks;
    int passed_checks;

    logic [7:0] mem [256];

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       strb;
        int         waits;
        logic       err_rdy;
        logic       err_wait;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    apb_master u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign prdata = mem[paddr];

    always @(posedge clk) begin
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one command from IDLE (called at a negedge) and follow it to IDLE again.
    task automatic run_txn(input vec_t v, input int idx);
        int fails_before;
        fails_before = total_checks - passed_checks;
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = ~v.write;
        cmd_addr  = ~v.addr;
        cmd_wdata = ~v.wdata;
        cmd_strb  = ~v.strb;
        pready    = 1'b0;
        pslverr   = 1'b0;
        chk("setup_sel_en", {30'd0, psel, penable}, 32'd2);
        chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk("setup_paddr", {24'd0, paddr}, {24'd0, v.addr});
        chk("setup_pwdata", {24'd0, pwdata}, {24'd0, v.wdata});
        chk("setup_pwrite_pstrb", {30'd0, pwrite, pstrb}, {30'd0, v.write, v.strb});
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge clk);
            chk("access_sel_en", {30'd0, psel, penable}, 32'd3);
            chk("access_paddr", {24'd0, paddr}, {24'd0, v.addr});
            chk("access_pwdata", {24'd0, pwdata}, {24'd0, v.wdata});
            chk("access_no_rsp", {31'd0, rsp_valid}, 32'd0);
            pready  = (k == v.waits);
            pslverr = (k == v.waits) ? v.err_rdy : v.err_wait;
        end
        @(negedge clk);
        pready  = 1'b0;
        pslverr = 1'b0;
        chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("resp_sel_en", {30'd0, psel, penable}, 32'd0);
        chk("resp_rdata", {24'd0, rsp_rdata}, {24'd0, v.exp_rdata});
        chk("resp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
        @(negedge clk);
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_paddr_hold", {24'd0, paddr}, {24'd0, v.addr});
        $display("txn %0d: %s addr=0x%02h wdata=0x%02h waits=%0d rdata=0x%02h err=%0b new_fails=%0d",
                 idx, v.write ? "WR" : "RD", v.addr, v.wdata, v.waits, rsp_rdata, rsp_err,
                 (total_checks - passed_checks) - fails_before);
    endtask

    initial begin
        int n_access;
        int hold_cycles;
        bit seen_rsp;

        total_checks  = 0;
        passed_checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        //          wr    addr   wdata  strb waits er_rdy er_wait exp_rd exp_err
        vecs[0] = '{1'b1, 8'h05, 8'hA5, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h12, 8'h3C, 1'b1, 0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h12, 8'h77, 1'b0, 0, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[3] = '{1'b1, 8'h40, 8'hC3, 1'b1, 3, 1'b0, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 8'h40, 8'h11, 1'b0, 2, 1'b1, 1'b0, 8'hC3, 1'b1};
        vecs[5] = '{1'b0, 8'h05, 8'h00, 1'b0, 1, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[6] = '{1'b1, 8'h80, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 8'h12, 8'h00, 1'b1, 0, 1'b0, 1'b0, 8'h3C, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b1;
        cmd_addr  = 8'hFF;
        cmd_wdata = 8'hFF;
        cmd_strb  = 1'b1;
        pready    = 1'b0;
        pslverr   = 1'b0;
        #1;
        chk("rst_sel_en_valid", {29'd0, psel, penable, rsp_valid}, 32'd0);
        chk("rst_pwrite_pstrb_err", {29'd0, pwrite, pstrb, rsp_err}, 32'd0);
        chk("rst_paddr_pwdata_rdata", {8'd0, paddr, pwdata, rsp_rdata}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_release_idle_no_sel", {31'd0, psel}, 32'd0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Completer never raises pready.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h00;
        cmd_strb  = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        n_access = 0;
        seen_rsp = 1'b0;
        for (int c = 0; c < 40 && !seen_rsp; c++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
            else if (psel && penable) n_access++;
        end
        chk("timeout_seen", {31'd0, seen_rsp}, 32'd1);
        chk("timeout_access_cycles", n_access, 32'd16);
        chk("timeout_err", {31'd0, rsp_err}, 32'd1);
        chk("timeout_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("timeout_psel_drop", {31'd0, psel}, 32'd0);
        @(negedge clk);
        chk("timeout_back_idle", {31'd0, cmd_ready}, 32'd1);
        $display("txn timeout: access_cycles=%0d err=%0b", n_access, rsp_err);
`else
        hold_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (psel && penable && !rsp_valid) hold_cycles++;
        end
        chk("no_timeout_psel_held", hold_cycles, 32'd100);
        #2 rst_n = 1'b0;
        #1 chk("no_timeout_reset_sel", {30'd0, psel, penable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn hang: psel held %0d cycles then reset", hold_cycles);
`endif

        // Reset while waiting in ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 8'h33;
        cmd_wdata = 8'h99;
        cmd_strb  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_access", {30'd0, psel, penable}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_async_sel_en", {30'd0, psel, penable}, 32'd0);
        chk("midrst_async_paddr", {24'd0, paddr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_rsp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp = 1'b1;
        end
        chk("midrst_no_rsp", {31'd0, seen_rsp}, 32'd0);
        chk("midrst_no_write", {24'd0, mem[8'h33]}, 32'd0);
        $display("txn reset-abort: rsp_seen=%0b", seen_rsp);
        run_txn(vecs[2], 8);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
